// File: rtl/ioctl_sdram_writer_pkg.sv
// Shared types for the ioctl download to SDRAM write path.
// The FIFO word carries a word address sized for the full 23-bit SDRAM address.
package ioctl_sdram_writer_pkg;

   localparam int DEFAULT_FIFO_DEPTH = 4;
   localparam int WORD_ADDR_W        = 22;

   typedef enum logic {
      IDLE,
      REQ
   } state_t;

   typedef logic [WORD_ADDR_W-1:0] word_addr_t;

   typedef struct packed {
      word_addr_t  addr;
      logic [31:0] data;
   } word_t;

   // Replace one byte lane of a 32-bit word.
   function automatic logic [31:0] put_byte(input logic [31:0] word,
                                            input logic [1:0]  lane,
                                            input logic [7:0]  value);
      logic [31:0] result;
      result                      = word;
      result[{lane, 3'b000} +: 8] = value;
      return result;
   endfunction

endpackage

// File: rtl/ioctl_sdram_writer_fifo.sv
// Synchronous FIFO; the head entry is visible on rdata whenever not empty.
// Push when full and pop when empty are ignored.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int             PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   // NOTE: the storage array is deliberately not reset; count alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ioctl_sdram_writer.sv
// Packs the ioctl download byte stream little-endian into 32-bit words and
// issues them one at a time on the SDRAM req/ack port through a small FIFO.
module ioctl_sdram_writer
   import ioctl_sdram_writer_pkg::*;
#(
   parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
   parameter int ADDR_WIDTH = 20
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] ioctl_addr,
   input  logic [7:0]            ioctl_data,
   input  logic                  ioctl_wr,
   input  logic                  ioctl_download,
   output logic [22:0]           sdram_addr,
   output logic [31:0]           sdram_data,
   output logic                  sdram_we,
   output logic                  sdram_req,
   input  logic                  sdram_ack,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow
);

   state_t      state;
   logic        download_q;
   logic        acc_valid;
   logic [31:0] acc_data;
   word_addr_t  acc_addr;
   logic        push_pending;
   logic        armed;

   logic        dl_rise;
   logic [1:0]  lane;
   word_addr_t  wr_addr;
   logic        base_valid;
   logic [31:0] base_data;

   logic        push;
   word_t       push_word;
   logic        nxt_valid;
   logic [31:0] nxt_data;
   word_addr_t  nxt_addr;
   logic        nxt_pending;

   logic        fifo_full;
   logic        fifo_empty;
   logic        pop;
   word_t       fifo_head;
   logic        done_cond;

   assign dl_rise    = ioctl_download & ~download_q;
   assign lane       = ioctl_addr[1:0];
   assign wr_addr    = word_addr_t'(ioctl_addr[ADDR_WIDTH-1:2]);
   // A new download discards any stale partial word before this cycle's byte lands.
   assign base_valid = acc_valid & ~dl_rise;
   assign base_data  = dl_rise ? 32'h0 : acc_data;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      push        = 1'b0;
      push_word   = '{addr: acc_addr, data: acc_data};
      nxt_valid   = base_valid;
      nxt_data    = base_data;
      nxt_addr    = acc_addr;
      nxt_pending = 1'b0;

      if (push_pending) begin
         push      = 1'b1;
         nxt_valid = 1'b0;
         nxt_data  = 32'h0;
      end else if (ioctl_wr) begin
         if (base_valid && (wr_addr != acc_addr)) begin
            push        = 1'b1;
            nxt_data    = put_byte(32'h0, lane, ioctl_data);
            nxt_addr    = wr_addr;
            nxt_valid   = 1'b1;
            nxt_pending = (lane == 2'd3);
         end else if (lane == 2'd3) begin
            push      = 1'b1;
            push_word = '{addr: wr_addr, data: put_byte(base_data, lane, ioctl_data)};
            nxt_valid = 1'b0;
            nxt_data  = 32'h0;
         end else begin
            nxt_data  = put_byte(base_data, lane, ioctl_data);
            nxt_addr  = wr_addr;
            nxt_valid = 1'b1;
         end
      end else if (!ioctl_download && base_valid) begin
         push      = 1'b1;
         nxt_valid = 1'b0;
         nxt_data  = 32'h0;
      end
   end

   sync_fifo #(
      .WIDTH ($bits(word_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata (push_word),
      .pop   (pop),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign pop       = (state == REQ) & sdram_ack;
   assign done_cond = ~ioctl_download & ~acc_valid & ~push_pending & fifo_empty & (state == IDLE);
   assign busy      = ioctl_download | ~fifo_empty | sdram_req | acc_valid | push_pending;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         download_q   <= 1'b0;
         acc_valid    <= 1'b0;
         acc_data     <= 32'h0;
         acc_addr     <= '0;
         push_pending <= 1'b0;
         armed        <= 1'b0;
         done         <= 1'b0;
         overflow     <= 1'b0;
         sdram_addr   <= 23'h0;
         sdram_data   <= 32'h0;
         sdram_we     <= 1'b0;
         sdram_req    <= 1'b0;
      end else begin
         download_q   <= ioctl_download;
         acc_valid    <= nxt_valid;
         acc_data     <= nxt_data;
         acc_addr     <= nxt_addr;
         push_pending <= nxt_pending;

         // done only reports on a download that has actually been seen.
         if (dl_rise) begin
            overflow <= 1'b0;
            done     <= 1'b0;
            armed    <= 1'b1;
         end else begin
            if (push && fifo_full) overflow <= 1'b1;
            if (armed && done_cond) begin
               done  <= 1'b1;
               armed <= 1'b0;
            end
         end

         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  sdram_addr <= {fifo_head.addr, 1'b0};
                  sdram_data <= fifo_head.data;
                  sdram_req  <= 1'b1;
                  sdram_we   <= 1'b1;
                  state      <= REQ;
               end
            end
            REQ: begin
               if (sdram_ack) begin
                  sdram_req <= 1'b0;
                  sdram_we  <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
